// File: rtl/sensor_cond_pkg.sv
// Shared types and helpers for the sensor sample conditioner.
package sensor_cond_pkg;

  localparam int unsigned DW_DEF  = 16;
  // Width of the generic clamp helper; DW up to this width is supported.
  localparam int unsigned CLAMP_W = 32;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } fill_state_e;

  // Unsigned clamp of v into [lo, hi].
  function automatic logic [CLAMP_W-1:0] clamp_val(
    input logic [CLAMP_W-1:0] v,
    input logic [CLAMP_W-1:0] lo,
    input logic [CLAMP_W-1:0] hi
  );
    logic [CLAMP_W-1:0] r;
    r = v;
    if (v < lo) begin
      r = lo;
    end else if (v > hi) begin
      r = hi;
    end
    return r;
  endfunction

endpackage

// File: rtl/median3.sv
// Combinational median of three unsigned values.
module median3
  import sensor_cond_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic [DW-1:0] c_i,
  output logic [DW-1:0] med_o
);

  logic [DW-1:0] lo_ab;
  logic [DW-1:0] hi_ab;
  logic [DW-1:0] mid;

  // median = max(min(a,b), min(max(a,b), c))
  always_comb begin
    lo_ab = (a_i < b_i) ? a_i : b_i;
    hi_ab = (a_i < b_i) ? b_i : a_i;
    mid   = (hi_ab < c_i) ? hi_ab : c_i;
    med_o = (lo_ab > mid) ? lo_ab : mid;
  end

endmodule

// File: rtl/sensor_sample_conditioner.sv
// Sensor sample conditioner: median-of-3 spike rejection, clamping, held
// measurement output and stale-input detection for the kalman_filter.
// Optional spike counter is built when SENSOR_COND_SPIKE_CNT_EN is defined.
module sensor_sample_conditioner
  import sensor_cond_pkg::*;
#(
  parameter int unsigned DW        = DW_DEF,
  parameter int unsigned MIN_VAL   = 0,
  parameter int unsigned MAX_VAL   = 1000,
  parameter int unsigned TIMEOUT   = 1000,
  parameter int unsigned SPIKE_THR = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic [DW-1:0] measurement,
  output logic          meas_valid,
  output logic          stale,
  output logic [15:0]   spike_cnt
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

  // Elaboration-time parameter sanity checks.
  if (MAX_VAL < MIN_VAL) begin : g_err_bounds
    $error("sensor_sample_conditioner: MAX_VAL must be >= MIN_VAL");
  end
  if (TIMEOUT < 2) begin : g_err_timeout
    $error("sensor_sample_conditioner: TIMEOUT must be >= 2");
  end
  if (64'(SPIKE_THR) >= (64'd1 << DW)) begin : g_err_thr
    $error("sensor_sample_conditioner: SPIKE_THR must fit in DW bits");
  end

  logic              rdy_q;
  logic              accept_c;
  logic              stage2_en_c;

  logic [DW-1:0]     w0_q, w1_q, w2_q;
  logic [DW-1:0]     w0_d, w1_d, w2_d;
  logic              v1_q, v1_d;

  fill_state_e       state_q;
  logic [1:0]        fill_cnt_q;

  logic [DW-1:0]     med_c;
  logic [DW-1:0]     sel_c;
  logic [DW-1:0]     clamped_c;

  logic [DW-1:0]     meas_q, meas_d;
  logic              meas_valid_q, meas_valid_d;

  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              stale_q, stale_d;

  assign s_ready     = rdy_q & ~flush;
  assign accept_c    = s_valid & s_ready;
  // A stage-1 result still in flight is dropped when flush is asserted.
  assign stage2_en_c = v1_q & ~flush;

  assign measurement = meas_q;
  assign meas_valid  = meas_valid_q;
  assign stale       = stale_q;

  median3 #(.DW(DW)) u_median3 (
    .a_i   (w0_q),
    .b_i   (w1_q),
    .c_i   (w2_q),
    .med_o (med_c)
  );

  // Stage 1: sample window shift, flush clear, and in-flight flag.
  always_comb begin
    w0_d = w0_q;
    w1_d = w1_q;
    w2_d = w2_q;
    v1_d = accept_c;
    if (flush) begin
      w0_d = '0;
      w1_d = '0;
      w2_d = '0;
    end else if (accept_c) begin
      w0_d = s_data;
      w1_d = w0_q;
      w2_d = w1_q;
    end
  end

  // Fill tracking: pass-through until three samples are held, then median.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      fill_cnt_q <= 2'd0;
    end else if (flush) begin
      state_q    <= FILL;
      fill_cnt_q <= 2'd0;
    end else if (accept_c) begin
      case (state_q)
        FILL: begin
          fill_cnt_q <= fill_cnt_q + 2'd1;
          if (fill_cnt_q == 2'd2) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          state_q <= RUN;
        end
        default: begin
          state_q    <= FILL;
          fill_cnt_q <= 2'd0;
        end
      endcase
    end
  end

  // Stage 2: select median or newest sample, clamp, and hold the result.
  always_comb begin
    sel_c        = (state_q == RUN) ? med_c : w0_q;
    clamped_c    = DW'(clamp_val(CLAMP_W'(sel_c), CLAMP_W'(MIN_VAL), CLAMP_W'(MAX_VAL)));
    meas_d       = meas_q;
    meas_valid_d = stage2_en_c;
    if (stage2_en_c) begin
      meas_d = clamped_c;
    end
  end

  // Idle counting and stale flag; flush leaves the idle count untouched.
  always_comb begin
    idle_d  = idle_q;
    stale_d = (idle_q == IDLE_W'(TIMEOUT));
    if (accept_c) begin
      idle_d = '0;
    end else if (!flush && (idle_q != IDLE_W'(TIMEOUT))) begin
      idle_d = idle_q + IDLE_W'(1);
    end
  end

  // Register bank for the datapath and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q        <= 1'b0;
      w0_q         <= '0;
      w1_q         <= '0;
      w2_q         <= '0;
      v1_q         <= 1'b0;
      meas_q       <= '0;
      meas_valid_q <= 1'b0;
      idle_q       <= '0;
      stale_q      <= 1'b0;
    end else begin
      rdy_q        <= 1'b1;
      w0_q         <= w0_d;
      w1_q         <= w1_d;
      w2_q         <= w2_d;
      v1_q         <= v1_d;
      meas_q       <= meas_d;
      meas_valid_q <= meas_valid_d;
      idle_q       <= idle_d;
      stale_q      <= stale_d;
    end
  end

`ifdef SENSOR_COND_SPIKE_CNT_EN
  logic [DW-1:0] diff_c;
  logic          spike_c;
  logic [15:0]   spike_q, spike_d;

  // Count RUN-mode results whose newest sample strays too far from the median.
  always_comb begin
    diff_c  = (w0_q >= med_c) ? (w0_q - med_c) : (med_c - w0_q);
    spike_c = (CLAMP_W'(diff_c) > CLAMP_W'(SPIKE_THR));
    spike_d = spike_q;
    if (stage2_en_c && (state_q == RUN) && spike_c && (spike_q != 16'hFFFF)) begin
      spike_d = spike_q + 16'd1;
    end
  end

  // Spike counter survives flush, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_q <= 16'd0;
    end else begin
      spike_q <= spike_d;
    end
  end

  assign spike_cnt = spike_q;
`else
  assign spike_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_sensor_sample_conditioner.sv
// Directed bench for sensor_sample_conditioner (MIN_VAL=10, MAX_VAL=1000).
module tb_sensor_sample_conditioner;

  localparam int unsigned DW      = 16;
  localparam int unsigned TIMEOUT = 1000;
`ifdef SENSOR_COND_SPIKE_CNT_EN
  localparam logic [15:0] EXP_SPIKE = 16'd1;
`else
  localparam logic [15:0] EXP_SPIKE = 16'd0;
`endif

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic [DW-1:0] measurement;
  logic          meas_valid;
  logic          stale;
  logic [15:0]   spike_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  sensor_sample_conditioner #(
    .DW(DW), .MIN_VAL(10), .MAX_VAL(1000), .TIMEOUT(TIMEOUT), .SPIKE_THR(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .measurement(measurement), .meas_valid(meas_valid),
    .stale(stale), .spike_cnt(spike_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = '0;
    #10;
    n_checks++; if (measurement !== 16'd0) begin n_fail++; $display("FAIL rst_meas: got %0d want 0", measurement); end
    n_checks++; if (meas_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mvalid: got %b want 0", meas_valid); end
    n_checks++; if (stale !== 1'b0) begin n_fail++; $display("FAIL rst_stale: got %b want 0", stale); end
    n_checks++; if (spike_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_spike: got %0d want 0", spike_cnt); end
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", s_ready); end
    #10;
    rst_n = 1'b1;
    #1;
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL rel_ready_pre_edge: got %b want 0", s_ready); end
    step();
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rel_ready: got %b want 1", s_ready); end
    n_checks++; if (stale !== 1'b0) begin n_fail++; $display("FAIL rel_stale: got %b want 0", stale); end
    n_checks++; if (measurement !== 16'd0) begin n_fail++; $display("FAIL rel_meas: got %0d want 0", measurement); end
  endtask

  task automatic test_median();
    logic [DW-1:0] d [4] = '{16'd100, 16'd120, 16'd110, 16'd130};
    logic [DW-1:0] e [4] = '{16'd100, 16'd120, 16'd110, 16'd120};
    for (int i = 0; i < 6; i++) begin
      s_valid = (i < 4);
      s_data  = (i < 4) ? d[i] : '0;
      step();
      if (i >= 1 && i <= 4) begin
        n_checks++; if (meas_valid !== 1'b1) begin n_fail++; $display("FAIL median_valid[%0d]: got %b want 1", i, meas_valid); end
        n_checks++; if (measurement !== e[i-1]) begin n_fail++; $display("FAIL median_meas[%0d]: got %0d want %0d", i, measurement, e[i-1]); end
      end else begin
        n_checks++; if (meas_valid !== 1'b0) begin n_fail++; $display("FAIL median_idle_valid[%0d]: got %b want 0", i, meas_valid); end
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic test_spike();
    logic [DW-1:0] d [4] = '{16'd100, 16'd100, 16'd900, 16'd100};
    do_flush();
    n_checks++; if (measurement !== 16'd120) begin n_fail++; $display("FAIL spike_flush_hold: got %0d want 120", measurement); end
    n_checks++; if (meas_valid !== 1'b0) begin n_fail++; $display("FAIL spike_flush_valid: got %b want 0", meas_valid); end
    for (int i = 0; i < 5; i++) begin
      s_valid = (i < 4);
      s_data  = (i < 4) ? d[i] : '0;
      step();
      if (i >= 1) begin
        n_checks++; if (meas_valid !== 1'b1 || measurement !== 16'd100) begin
          n_fail++; $display("FAIL spike_out[%0d]: got %0d/%b want 100/1", i, measurement, meas_valid);
        end
      end
    end
    s_valid = 1'b0;
    step();
    n_checks++; if (spike_cnt !== EXP_SPIKE) begin n_fail++; $display("FAIL spike_cnt: got %0d want %0d", spike_cnt, EXP_SPIKE); end
  endtask

  task automatic test_clamp();
    do_flush();
    s_valid = 1'b1; s_data = 16'd5000;
    step();
    s_data = 16'd0;
    step();
    s_valid = 1'b0;
    n_checks++; if (measurement !== 16'd1000 || meas_valid !== 1'b1) begin
      n_fail++; $display("FAIL clamp_high: got %0d/%b want 1000/1", measurement, meas_valid);
    end
    step();
    n_checks++; if (measurement !== 16'd10 || meas_valid !== 1'b1) begin
      n_fail++; $display("FAIL clamp_low: got %0d/%b want 10/1", measurement, meas_valid);
    end
    step();
  endtask

  task automatic test_flush_with_valid();
    flush = 1'b1; s_valid = 1'b1; s_data = 16'd77;
    #1;
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL flushv_ready: got %b want 0", s_ready); end
    step();
    flush = 1'b0; s_data = 16'd200;
    step();
    s_valid = 1'b0;
    n_checks++; if (meas_valid !== 1'b0 || measurement !== 16'd10) begin
      n_fail++; $display("FAIL flushv_not_accepted: got %0d/%b want 10/0", measurement, meas_valid);
    end
    step();
    n_checks++; if (measurement !== 16'd200 || meas_valid !== 1'b1) begin
      n_fail++; $display("FAIL flushv_pass: got %0d/%b want 200/1", measurement, meas_valid);
    end
  endtask

  task automatic test_flush_inflight();
    s_valid = 1'b1; s_data = 16'd500;
    step();
    s_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_checks++; if (meas_valid !== 1'b0 || measurement !== 16'd200) begin
      n_fail++; $display("FAIL inflight_drop: got %0d/%b want 200/0", measurement, meas_valid);
    end
  endtask

  task automatic test_stale();
    for (int i = 0; i < 990; i++) step();
    n_checks++; if (stale !== 1'b0) begin n_fail++; $display("FAIL stale_early: got %b want 0", stale); end
    for (int i = 0; i < 20; i++) step();
    n_checks++; if (stale !== 1'b1) begin n_fail++; $display("FAIL stale_set: got %b want 1", stale); end
    for (int i = 0; i < 20; i++) step();
    n_checks++; if (stale !== 1'b1) begin n_fail++; $display("FAIL stale_hold: got %b want 1", stale); end
    n_checks++; if (measurement !== 16'd200 || meas_valid !== 1'b0) begin
      n_fail++; $display("FAIL stale_meas_hold: got %0d/%b want 200/0", measurement, meas_valid);
    end
    s_valid = 1'b1; s_data = 16'd300;
    step();
    s_valid = 1'b0;
    n_checks++; if (stale !== 1'b1) begin n_fail++; $display("FAIL stale_accept_edge: got %b want 1", stale); end
    step();
    n_checks++; if (stale !== 1'b0) begin n_fail++; $display("FAIL stale_clear: got %b want 0", stale); end
    n_checks++; if (measurement !== 16'd300 || meas_valid !== 1'b1) begin
      n_fail++; $display("FAIL stale_new_meas: got %0d/%b want 300/1", measurement, meas_valid);
    end
  endtask

  task automatic test_reset_mid();
    s_valid = 1'b1; s_data = 16'd400;
    step();
    s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (measurement !== 16'd0 || meas_valid !== 1'b0 || s_ready !== 1'b0) begin
      n_fail++; $display("FAIL midrst_async: got %0d/%b/%b want 0/0/0", measurement, meas_valid, s_ready);
    end
    #2 rst_n = 1'b1;
    step();
    n_checks++; if (meas_valid !== 1'b0 || measurement !== 16'd0 || s_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_inflight: got %0d/%b/%b want 0/0/1", measurement, meas_valid, s_ready);
    end
    n_checks++; if (spike_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_spike: got %0d want 0", spike_cnt); end
  endtask

  initial begin
    test_reset();
    test_median();
    test_spike();
    test_clamp();
    test_flush_with_valid();
    test_flush_inflight();
    test_stale();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
